// File: rtl/smem_dram_arbiter.sv
// Round-robin arbiter between the forward and backward occurrence-table fetch pipelines
// onto a single DRAM request port, with in-flight tracking, back-pressure and flush/drain.
module smem_dram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              Clk_32UI,
  input  logic              reset,

  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  input  logic [9:0]        f_req_read_num,
  output logic              f_req_ready,

  input  logic              b_req_valid,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [9:0]        b_req_read_num,
  output logic              b_req_ready,

  output logic              dram_req_valid,
  output logic [ADDR_W-1:0] dram_req_addr,
  output logic [9:0]        dram_req_read_num,
  output logic              dram_req_src,
  input  logic              dram_req_ready,

  input  logic              DRAM_get,
  input  logic              flush,
  output logic              drained,
  output logic              stall,
  output logic [CNT_W-1:0]  inflight,
  output logic              underflow_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic             SRC_FWD = 1'b0;
  localparam logic             SRC_BWD = 1'b1;

  state_t state, state_nxt;
  logic   last_grant;
  logic   load_ok;
  logic   win_bwd;
  logic   grant;
  logic   dec;

  // Eligibility uses the registered count only, so a same-cycle response never opens a slot.
  assign load_ok = ((state == IDLE) || ((state == HOLD) && dram_req_ready))
                   && (inflight < MAX_CNT) && !flush;

  assign win_bwd = b_req_valid && (!f_req_valid || (last_grant == SRC_FWD));
  assign grant   = load_ok && (f_req_valid || b_req_valid);
  assign dec     = DRAM_get && (inflight != '0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk_32UI) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (flush)      state_nxt = DRAIN;
        else if (grant) state_nxt = HOLD;
      end
      HOLD: begin
        if (dram_req_ready) begin
          if (grant)      state_nxt = HOLD;
          else if (flush) state_nxt = DRAIN;
          else            state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (!flush) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    f_req_ready    = grant && !win_bwd;
    b_req_ready    = grant && win_bwd;
    dram_req_valid = (state == HOLD);
    drained        = (state == DRAIN) && (inflight == '0);
    stall          = (inflight == MAX_CNT) || flush || (state == DRAIN);
  end

  // Held request and round-robin pointer; the pointer resets to backward so forward wins first.
  // NOTE: the held request registers are reset too, so a discarded request never leaks out.
  always_ff @(posedge Clk_32UI) begin
    if (reset) begin
      dram_req_addr     <= '0;
      dram_req_read_num <= '0;
      dram_req_src      <= SRC_FWD;
      last_grant        <= SRC_BWD;
    end else if (grant) begin
      dram_req_addr     <= win_bwd ? b_req_addr     : f_req_addr;
      dram_req_read_num <= win_bwd ? b_req_read_num : f_req_read_num;
      dram_req_src      <= win_bwd;
      last_grant        <= win_bwd;
    end
  end

  // In-flight counter and sticky underflow flag.
  always_ff @(posedge Clk_32UI) begin
    if (reset) begin
      inflight      <= '0;
      underflow_err <= 1'b0;
    end else begin
      unique case ({grant, dec})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      if (DRAM_get && (inflight == '0)) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_smem_dram_arbiter.sv
// Directed bench for smem_dram_arbiter: a table of per-cycle vectors followed by
// hand-written sequences for fill-to-limit, reset-in-HOLD and underflow.
module tb_smem_dram_arbiter;

  localparam int ADDR_W  = 32;
  localparam int MAX_OUT = 32;
  localparam int CNT_W   = 6;

  logic              Clk_32UI;
  logic              reset;
  logic              f_req_valid, b_req_valid;
  logic [ADDR_W-1:0] f_req_addr, b_req_addr;
  logic [9:0]        f_req_read_num, b_req_read_num;
  logic              f_req_ready, b_req_ready;
  logic              dram_req_valid;
  logic [ADDR_W-1:0] dram_req_addr;
  logic [9:0]        dram_req_read_num;
  logic              dram_req_src;
  logic              dram_req_ready;
  logic              DRAM_get;
  logic              flush;
  logic              drained;
  logic              stall;
  logic [CNT_W-1:0]  inflight;
  logic              underflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  smem_dram_arbiter #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .Clk_32UI          (Clk_32UI),
    .reset             (reset),
    .f_req_valid       (f_req_valid),
    .f_req_addr        (f_req_addr),
    .f_req_read_num    (f_req_read_num),
    .f_req_ready       (f_req_ready),
    .b_req_valid       (b_req_valid),
    .b_req_addr        (b_req_addr),
    .b_req_read_num    (b_req_read_num),
    .b_req_ready       (b_req_ready),
    .dram_req_valid    (dram_req_valid),
    .dram_req_addr     (dram_req_addr),
    .dram_req_read_num (dram_req_read_num),
    .dram_req_src      (dram_req_src),
    .dram_req_ready    (dram_req_ready),
    .DRAM_get          (DRAM_get),
    .flush             (flush),
    .drained           (drained),
    .stall             (stall),
    .inflight          (inflight),
    .underflow_err     (underflow_err)
  );

  initial Clk_32UI = 1'b0;
  always #5 Clk_32UI = ~Clk_32UI;

  // One record per cycle: inputs {fv,bv,rdy,get,flush}, expected {f_ready,b_ready,dvalid,src},
  // expected held address, inflight, and {stall,drained}.
  typedef struct {
    logic [4:0]  in;
    logic [3:0]  ex;
    logic [31:0] addr;
    int          inf;
    logic [1:0]  sd;
  } vec_t;

  vec_t vecs[20];
  int   n_vec = 0;

  task automatic add(input logic [4:0] in, input logic [3:0] ex, input logic [31:0] addr,
                     input int inf, input logic [1:0] sd);
    vecs[n_vec] = '{in: in, ex: ex, addr: addr, inf: inf, sd: sd};
    n_vec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    f_req_valid    = 1'b0;
    b_req_valid    = 1'b0;
    f_req_addr     = '0;
    b_req_addr     = '0;
    f_req_read_num = '0;
    b_req_read_num = '0;
    dram_req_ready = 1'b0;
    DRAM_get       = 1'b0;
    flush          = 1'b0;
  endtask

  // Leaves the bench at a negedge with reset released and inputs idle.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge Clk_32UI);
    reset = 1'b0;
  endtask

  initial begin
    int grants;

    // Directed per-cycle table.
    add(5'b11100, 4'b1000, 32'h0,    0, 2'b00);
    add(5'b11100, 4'b0110, 32'hA000, 1, 2'b00);
    add(5'b11100, 4'b1011, 32'hB001, 2, 2'b00);
    add(5'b10000, 4'b0010, 32'hA002, 3, 2'b00);
    add(5'b10000, 4'b0010, 32'hA002, 3, 2'b00);
    add(5'b10000, 4'b0010, 32'hA002, 3, 2'b00);
    add(5'b10100, 4'b1010, 32'hA002, 3, 2'b00);
    add(5'b00100, 4'b0010, 32'hA006, 4, 2'b00);
    add(5'b00010, 4'b0000, 32'hA006, 4, 2'b00);
    add(5'b01010, 4'b0100, 32'hA006, 3, 2'b00);
    add(5'b10001, 4'b0011, 32'hB009, 3, 2'b10);
    add(5'b10101, 4'b0011, 32'hB009, 3, 2'b10);
    add(5'b10001, 4'b0001, 32'hB009, 3, 2'b10);
    add(5'b00011, 4'b0001, 32'hB009, 3, 2'b10);
    add(5'b00011, 4'b0001, 32'hB009, 2, 2'b10);
    add(5'b00011, 4'b0001, 32'hB009, 1, 2'b10);
    add(5'b00001, 4'b0001, 32'hB009, 0, 2'b11);
    add(5'b10000, 4'b0001, 32'hB009, 0, 2'b11);
    add(5'b10000, 4'b1001, 32'hB009, 0, 2'b00);
    add(5'b00000, 4'b0010, 32'hA012, 1, 2'b00);

    idle_inputs();
    reset = 1'b1;
    @(negedge Clk_32UI);
    @(negedge Clk_32UI);
    #1;
    check("reset.dvalid",    32'(dram_req_valid), 32'h0);
    check("reset.inflight",  32'(inflight),       32'h0);
    check("reset.stall",     32'(stall),          32'h0);
    check("reset.drained",   32'(drained),        32'h0);
    check("reset.underflow", 32'(underflow_err),  32'h0);
    check("reset.addr",      dram_req_addr,       32'h0);
    @(negedge Clk_32UI);
    reset = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      f_req_valid    = vecs[i].in[4];
      b_req_valid    = vecs[i].in[3];
      dram_req_ready = vecs[i].in[2];
      DRAM_get       = vecs[i].in[1];
      flush          = vecs[i].in[0];
      f_req_addr     = 32'hA000 + 32'(i);
      b_req_addr     = 32'hB000 + 32'(i);
      f_req_read_num = 10'(i);
      b_req_read_num = 10'h200 | 10'(i);
      #1;
      check($sformatf("v%0d.f_ready", i),  32'(f_req_ready),      32'(vecs[i].ex[3]));
      check($sformatf("v%0d.b_ready", i),  32'(b_req_ready),      32'(vecs[i].ex[2]));
      check($sformatf("v%0d.dvalid", i),   32'(dram_req_valid),   32'(vecs[i].ex[1]));
      check($sformatf("v%0d.src", i),      32'(dram_req_src),     32'(vecs[i].ex[0]));
      check($sformatf("v%0d.addr", i),     dram_req_addr,         vecs[i].addr);
      check($sformatf("v%0d.tag", i),      32'(dram_req_read_num),
            32'({vecs[i].ex[0], vecs[i].addr[8:0]}));
      check($sformatf("v%0d.inflight", i), 32'(inflight),         32'(vecs[i].inf));
      check($sformatf("v%0d.stall", i),    32'(stall),            32'(vecs[i].sd[1]));
      check($sformatf("v%0d.drained", i),  32'(drained),          32'(vecs[i].sd[0]));
      @(negedge Clk_32UI);
    end

    // Fill to the in-flight limit with forward-only traffic and no responses.
    do_reset();
    grants = 0;
    f_req_valid    = 1'b1;
    dram_req_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      f_req_addr = 32'h100 + 32'(c);
      #1;
      if (f_req_ready) grants++;
      @(negedge Clk_32UI);
    end
    #1;
    check("fill.grants",   32'(grants),      32'd32);
    check("fill.inflight", 32'(inflight),    32'd32);
    check("fill.stall",    32'(stall),       32'h1);
    check("fill.f_ready",  32'(f_req_ready), 32'h0);
    @(negedge Clk_32UI);
    DRAM_get = 1'b1;
    #1;
    check("fill.get_no_grant", 32'(f_req_ready), 32'h0);
    @(negedge Clk_32UI);
    DRAM_get = 1'b0;
    #1;
    check("fill.after_get_inflight", 32'(inflight),    32'd31);
    check("fill.after_get_f_ready",  32'(f_req_ready), 32'h1);
    check("fill.after_get_stall",    32'(stall),       32'h0);
    @(negedge Clk_32UI);

    // Reset while holding a request with seven in flight; last grant was forward.
    do_reset();
    f_req_valid    = 1'b1;
    dram_req_ready = 1'b1;
    repeat (7) @(negedge Clk_32UI);
    f_req_valid    = 1'b0;
    dram_req_ready = 1'b0;
    #1;
    check("rsthold.pre_inflight", 32'(inflight),       32'd7);
    check("rsthold.pre_dvalid",   32'(dram_req_valid), 32'h1);
    reset       = 1'b1;
    f_req_valid = 1'b1;
    b_req_valid = 1'b1;
    @(negedge Clk_32UI);
    reset = 1'b0;
    #1;
    check("rsthold.dvalid",   32'(dram_req_valid), 32'h0);
    check("rsthold.inflight", 32'(inflight),       32'h0);
    check("rsthold.addr",     dram_req_addr,       32'h0);
    check("rsthold.f_ready",  32'(f_req_ready),    32'h1);
    check("rsthold.b_ready",  32'(b_req_ready),    32'h0);
    @(negedge Clk_32UI);

    // Response with nothing outstanding.
    do_reset();
    DRAM_get = 1'b1;
    #1;
    check("uflow.before", 32'(underflow_err), 32'h0);
    @(negedge Clk_32UI);
    DRAM_get = 1'b0;
    #1;
    check("uflow.set",      32'(underflow_err), 32'h1);
    check("uflow.inflight", 32'(inflight),      32'h0);
    repeat (3) @(negedge Clk_32UI);
    #1;
    check("uflow.sticky", 32'(underflow_err), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
